// File: rtl/kb_event_scheduler.sv
// Keyboard/mouse event scheduler: edge-captures events into two FIFOs, forwards them
// round-robin through a registered output slot, and rate-limits LED commands.
module kb_event_scheduler #(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] LED_GAP = 16'd10600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kb_data_avail,
  input  logic        kb_is_mouse,
  input  logic [15:0] kb_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [15:0] evt_data,
  output logic        evt_is_mouse,
  input  logic        led_req,
  input  logic [1:0]  led_val,
  output logic        led_data_valid,
  output logic [1:0]  led_data,
  output logic        kb_ovf,
  output logic        ms_ovf,
  input  logic        ovf_clr
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam int            KB       = 0;
  localparam int            MS       = 1;

  logic                avail_q, avail_d;
  logic [15:0]         mem_q [2][DEPTH];
  logic [1:0][AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0][AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0][AW:0]    cnt_q, cnt_d;
  logic [1:0]          push, pop, acc, drop, not_empty, full;
  logic [1:0][15:0]    head;
  logic                last_grant_q, last_grant_d;
  logic                evt_valid_q, evt_valid_d;
  logic [15:0]         evt_data_q, evt_data_d;
  logic                evt_is_mouse_q, evt_is_mouse_d;
  logic                kb_ovf_q, kb_ovf_d;
  logic                ms_ovf_q, ms_ovf_d;
  logic                led_pending_q, led_pending_d;
  logic [1:0]          led_pend_val_q, led_pend_val_d;
  logic [15:0]         gap_q, gap_d;
  logic                led_data_valid_q, led_data_valid_d;
  logic [1:0]          led_data_q, led_data_d;
  logic                capture, slot_load, grant_ms, led_issue;

  // NOTE: every variable gets a default at the top of the block with blocking
  // assignments, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    avail_d = kb_data_avail;
    capture = kb_data_avail & ~avail_q;
    push    = {capture & kb_is_mouse, capture & ~kb_is_mouse};

    for (int i = 0; i < 2; i++) begin
      not_empty[i] = (cnt_q[i] != '0);
      full[i]      = (cnt_q[i] == CNT_FULL);
      head[i]      = mem_q[i][rd_ptr_q[i]];
    end

    // Mouse wins when it alone has data, or when both do and keyboard went last.
    slot_load = ~evt_valid_q | evt_ready;
    grant_ms  = not_empty[MS] & (~not_empty[KB] | ~last_grant_q);
    pop[KB]   = slot_load & not_empty[KB] & ~grant_ms;
    pop[MS]   = slot_load & grant_ms;

    evt_valid_d    = evt_valid_q;
    evt_data_d     = evt_data_q;
    evt_is_mouse_d = evt_is_mouse_q;
    last_grant_d   = last_grant_q;
    if (slot_load) begin
      evt_valid_d = |pop;
      if (|pop) begin
        evt_data_d     = head[grant_ms];
        evt_is_mouse_d = grant_ms;
        last_grant_d   = grant_ms;
      end
    end

    // A pop on the same edge frees the slot a full queue needs for the new entry.
    for (int i = 0; i < 2; i++) begin
      acc[i]      = push[i] & (~full[i] | pop[i]);
      drop[i]     = push[i] & full[i] & ~pop[i];
      wr_ptr_d[i] = acc[i] ? wr_ptr_q[i] + PTR_ONE : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i] ? rd_ptr_q[i] + PTR_ONE : rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (acc[i] & ~pop[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (~acc[i] & pop[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end

    kb_ovf_d = (kb_ovf_q & ~ovf_clr) | drop[KB];
    ms_ovf_d = (ms_ovf_q & ~ovf_clr) | drop[MS];

    led_data_valid_d = 1'b0;
    led_data_d       = led_data_q;
    led_pending_d    = led_pending_q;
    led_pend_val_d   = led_pend_val_q;
    gap_d            = (gap_q != '0) ? gap_q - 16'd1 : gap_q;
    led_issue        = led_pending_q & (gap_q == '0) & ~kb_data_avail;
    if (led_issue) begin
      led_data_valid_d = 1'b1;
      led_data_d       = led_pend_val_q;
      led_pending_d    = 1'b0;
      gap_d            = LED_GAP - 16'd1;
    end
    // A request on the issue edge becomes the next pending command.
    if (led_req) begin
      led_pending_d  = 1'b1;
      led_pend_val_d = led_val;
    end
  end

  // NOTE: queue storage has no reset; pointers and counts alone decide which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) mem_q[i][wr_ptr_q[i]] <= kb_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avail_q          <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      last_grant_q     <= 1'b1;
      evt_valid_q      <= 1'b0;
      evt_data_q       <= '0;
      evt_is_mouse_q   <= 1'b0;
      kb_ovf_q         <= 1'b0;
      ms_ovf_q         <= 1'b0;
      led_pending_q    <= 1'b0;
      led_pend_val_q   <= 2'b00;
      gap_q            <= '0;
      led_data_valid_q <= 1'b0;
      led_data_q       <= 2'b00;
    end else begin
      avail_q          <= avail_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cnt_q            <= cnt_d;
      last_grant_q     <= last_grant_d;
      evt_valid_q      <= evt_valid_d;
      evt_data_q       <= evt_data_d;
      evt_is_mouse_q   <= evt_is_mouse_d;
      kb_ovf_q         <= kb_ovf_d;
      ms_ovf_q         <= ms_ovf_d;
      led_pending_q    <= led_pending_d;
      led_pend_val_q   <= led_pend_val_d;
      gap_q            <= gap_d;
      led_data_valid_q <= led_data_valid_d;
      led_data_q       <= led_data_d;
    end
  end

  assign evt_valid      = evt_valid_q;
  assign evt_data       = evt_data_q;
  assign evt_is_mouse   = evt_is_mouse_q;
  assign kb_ovf         = kb_ovf_q;
  assign ms_ovf         = ms_ovf_q;
  assign led_data_valid = led_data_valid_q;
  assign led_data       = led_data_q;

endmodule

// File: tb/tb_kb_event_scheduler.sv
// Scoreboard bench for kb_event_scheduler: directed stimulus pushes expected events,
// a negedge monitor pops and compares every accepted output event.
module tb_kb_event_scheduler;
  localparam int          DEPTH   = 4;
  localparam int          G       = 20;
  localparam logic [15:0] LED_GAP = 16'd20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kb_data_avail = 1'b0;
  logic        kb_is_mouse = 1'b0;
  logic [15:0] kb_data = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [15:0] evt_data;
  logic        evt_is_mouse;
  logic        led_req = 1'b0;
  logic [1:0]  led_val = 2'b00;
  logic        led_data_valid;
  logic [1:0]  led_data;
  logic        kb_ovf;
  logic        ms_ovf;
  logic        ovf_clr = 1'b0;

  always #5 clk = ~clk;

  kb_event_scheduler #(.DEPTH(DEPTH), .LED_GAP(LED_GAP)) dut (
    .clk            (clk),
    .reset          (reset),
    .kb_data_avail  (kb_data_avail),
    .kb_is_mouse    (kb_is_mouse),
    .kb_data        (kb_data),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .evt_is_mouse   (evt_is_mouse),
    .led_req        (led_req),
    .led_val        (led_val),
    .led_data_valid (led_data_valid),
    .led_data       (led_data),
    .kb_ovf         (kb_ovf),
    .ms_ovf         (ms_ovf),
    .ovf_clr        (ovf_clr)
  );

  typedef struct packed {
    logic        is_mouse;
    logic [15:0] data;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulse;
  int   n_ev;
  int   pulse_cyc [4];
  logic [1:0] pulse_val [4];
  logic [1:0] pv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic m, input logic [15:0] d, input logic expect_it);
    kb_is_mouse   = m;
    kb_data       = d;
    kb_data_avail = 1'b1;
    if (expect_it) exp_q.push_back({m, d});
    step(1);
    kb_data_avail = 1'b0;
    step(1);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      step(1);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    step(1);
    check({name, "_idle"}, {31'd0, evt_valid}, 0);
  endtask

  always @(negedge clk) begin : monitor
    evt_t e;
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", {15'd0, evt_is_mouse, evt_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("evt", {15'd0, evt_is_mouse, evt_data}, {15'd0, e});
      end
    end
  end

  initial begin
    step(2);
    check("rst_evt_valid", {31'd0, evt_valid}, 0);
    check("rst_evt_data", {16'd0, evt_data}, 0);
    check("rst_evt_is_mouse", {31'd0, evt_is_mouse}, 0);
    check("rst_led_valid", {31'd0, led_data_valid}, 0);
    check("rst_led_data", {30'd0, led_data}, 0);
    check("rst_kb_ovf", {31'd0, kb_ovf}, 0);
    check("rst_ms_ovf", {31'd0, ms_ovf}, 0);
    reset = 1'b0;
    step(1);

    // Single capture: avail high 5 cycles, forwarded one edge after capture, once.
    evt_ready     = 1'b1;
    kb_is_mouse   = 1'b0;
    kb_data       = 16'h1234;
    kb_data_avail = 1'b1;
    exp_q.push_back({1'b0, 16'h1234});
    step(1);
    check("lat_capture_edge", {31'd0, evt_valid}, 0);
    step(1);
    check("lat_valid", {31'd0, evt_valid}, 1);
    check("lat_data", {16'd0, evt_data}, 32'h1234);
    check("lat_is_mouse", {31'd0, evt_is_mouse}, 0);
    step(1);
    check("one_cycle", {31'd0, evt_valid}, 0);
    step(2);
    kb_data_avail = 1'b0;
    step(2);
    check("no_recapture", {31'd0, evt_valid}, 0);
    wait_drain("single");

    // Keyboard fill: slot + DEPTH entries, sixth capture overflows.
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) capture(1'b0, 16'(i), 1'b1);
    check("kb_ovf_full_ok", {31'd0, kb_ovf}, 0);
    check("slot_hold_valid", {31'd0, evt_valid}, 1);
    check("slot_hold_data", {16'd0, evt_data}, 32'h0001);
    capture(1'b0, 16'h0006, 1'b0);
    check("kb_ovf_set", {31'd0, kb_ovf}, 1);
    check("ms_ovf_quiet", {31'd0, ms_ovf}, 0);
    check("slot_hold_data2", {16'd0, evt_data}, 32'h0001);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("kb_ovf_clr", {31'd0, kb_ovf}, 0);
    evt_ready = 1'b1;
    wait_drain("kb_fill_drain");

    // Mouse fill with clear coincident with the overflowing capture: set wins.
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) capture(1'b1, 16'h0100 + 16'(i), 1'b1);
    kb_is_mouse   = 1'b1;
    kb_data       = 16'h0106;
    kb_data_avail = 1'b1;
    ovf_clr       = 1'b1;
    step(1);
    ovf_clr       = 1'b0;
    kb_data_avail = 1'b0;
    step(1);
    check("ms_ovf_set_wins", {31'd0, ms_ovf}, 1);
    check("kb_ovf_quiet", {31'd0, kb_ovf}, 0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ms_ovf_clr", {31'd0, ms_ovf}, 0);
    evt_ready = 1'b1;
    wait_drain("ms_fill_drain");

    // Capture into a full queue on the same edge as a pop is accepted.
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) capture(1'b0, 16'h0C00 + 16'(i), 1'b1);
    evt_ready = 1'b1;
    capture(1'b0, 16'h0C06, 1'b1);
    check("full_pop_no_ovf", {31'd0, kb_ovf}, 0);
    wait_drain("full_pop_drain");

    // Interleave: A1 lands in the slot, then strict alternation one per cycle.
    evt_ready = 1'b0;
    capture(1'b0, 16'h00A1, 1'b0);
    capture(1'b0, 16'h00A2, 1'b0);
    capture(1'b1, 16'h00B1, 1'b0);
    capture(1'b1, 16'h00B2, 1'b0);
    exp_q.push_back({1'b0, 16'h00A1});
    exp_q.push_back({1'b1, 16'h00B1});
    exp_q.push_back({1'b0, 16'h00A2});
    exp_q.push_back({1'b1, 16'h00B2});
    evt_ready = 1'b1;
    step(4);
    check("rr_four_cycles", exp_q.size(), 0);
    check("rr_done", {31'd0, evt_valid}, 0);
    wait_drain("rr_drain");

    // LED: idle request issues on the edge after it is latched.
    led_val = 2'b11;
    led_req = 1'b1;
    step(1);
    led_req = 1'b0;
    check("led_latch_edge", {31'd0, led_data_valid}, 0);
    step(1);
    check("led_pulse1", {31'd0, led_data_valid}, 1);
    check("led_data1", {30'd0, led_data}, 32'd3);
    n_pulse = 0;
    for (int i = 1; i <= 2 * G + 5; i++) begin
      if (i == 1) begin
        led_req = 1'b1;
        led_val = 2'b01;
      end else if (i == 2) begin
        led_val = 2'b10;
      end else if (i == 3) begin
        led_req = 1'b0;
      end else if (i == G) begin
        led_req = 1'b1;
        led_val = 2'b01;
      end else if (i == G + 1) begin
        led_req = 1'b0;
      end
      step(1);
      if (i == 5) check("led_hold", {30'd0, led_data}, 32'd3);
      if (led_data_valid) begin
        if (n_pulse < 4) begin
          pulse_cyc[n_pulse] = i;
          pulse_val[n_pulse] = led_data;
        end
        n_pulse++;
      end
    end
    check("led_pulse_count", n_pulse, 2);
    check("led_gap_cycles", pulse_cyc[0], G);
    check("led_last_wins", {30'd0, pulse_val[0]}, 32'd2);
    check("led_issue_edge_req_cycles", pulse_cyc[1], 2 * G);
    check("led_issue_edge_req_val", {30'd0, pulse_val[1]}, 32'd1);

    // LED blocked while kb_data_avail is high, issued once it falls.
    step(G);
    evt_ready     = 1'b1;
    kb_is_mouse   = 1'b0;
    kb_data       = 16'h0BEE;
    kb_data_avail = 1'b1;
    exp_q.push_back({1'b0, 16'h0BEE});
    led_req = 1'b1;
    led_val = 2'b10;
    step(1);
    led_req = 1'b0;
    n_pulse = 0;
    repeat (6) begin
      step(1);
      if (led_data_valid) n_pulse++;
    end
    check("led_blocked", n_pulse, 0);
    kb_data_avail = 1'b0;
    pv = 2'b00;
    repeat (4) begin
      step(1);
      if (led_data_valid) begin
        n_pulse++;
        pv = led_data;
      end
    end
    check("led_after_avail", n_pulse, 1);
    check("led_after_avail_val", {30'd0, pv}, 32'd2);
    wait_drain("avail_evt");

    // Reset mid-operation with queued events and a pending LED command.
    led_req = 1'b1;
    led_val = 2'b11;
    step(1);
    led_req   = 1'b0;
    evt_ready = 1'b0;
    capture(1'b0, 16'h00D1, 1'b0);
    capture(1'b0, 16'h00D2, 1'b0);
    capture(1'b0, 16'h00D3, 1'b0);
    reset = 1'b1;
    #1;
    check("async_evt_valid", {31'd0, evt_valid}, 0);
    check("async_evt_data", {16'd0, evt_data}, 0);
    check("async_led_data", {30'd0, led_data}, 0);
    check("async_led_valid", {31'd0, led_data_valid}, 0);
    step(1);
    reset     = 1'b0;
    evt_ready = 1'b1;
    n_pulse   = 0;
    n_ev      = 0;
    repeat (2 * G + 5) begin
      step(1);
      if (led_data_valid) n_pulse++;
      if (evt_valid) n_ev++;
    end
    check("post_rst_no_led", n_pulse, 0);
    check("post_rst_no_evt", n_ev, 0);

    // kb_data_avail already high at reset release captures on the first edge.
    reset         = 1'b1;
    evt_ready     = 1'b0;
    kb_is_mouse   = 1'b1;
    kb_data       = 16'h0F0F;
    kb_data_avail = 1'b1;
    step(1);
    reset = 1'b0;
    exp_q.push_back({1'b1, 16'h0F0F});
    step(1);
    check("rel_capture_edge", {31'd0, evt_valid}, 0);
    step(1);
    check("rel_valid", {31'd0, evt_valid}, 1);
    check("rel_is_mouse", {31'd0, evt_is_mouse}, 1);
    kb_data_avail = 1'b0;
    evt_ready     = 1'b1;
    wait_drain("rel_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kb_event_scheduler.md
KB_EVENT_SCHEDULER -- requirements
Module: kb_event_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: entries per event queue (power of 2, 2..16).
REQ-002 Parameter LED_GAP, default 16'd10600: minimum clk cycles between LED commands (~2.1 ms at 200 ns clk).
REQ-003 clk  input  1  monitor clock; all state on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 kb_data_avail  input  1  level from keyboard block; high while kb_data/kb_is_mouse valid.
REQ-006 kb_is_mouse  input  1  0 = keyboard event, 1 = mouse event.
REQ-007 kb_data  input  16  event payload.
REQ-008 evt_valid  output  1  output event valid.
REQ-009 evt_ready  input  1  consumer accepts event when evt_valid & evt_ready.
REQ-010 evt_data  output  16  event payload.
REQ-011 evt_is_mouse  output  1  source of evt_data.
REQ-012 led_req  input  1  one-cycle host request to set LEDs.
REQ-013 led_val  input  2  requested LED state, sampled with led_req.
REQ-014 led_data_valid  output  1  one-cycle LED command pulse to keyboard block.
REQ-015 led_data  output  2  LED state, valid with led_data_valid.
REQ-016 kb_ovf  output  1  sticky: keyboard event dropped.
REQ-017 ms_ovf  output  1  sticky: mouse event dropped.
REQ-018 ovf_clr  input  1  one-cycle pulse clears kb_ovf and ms_ovf.

Function
REQ-019 Capture: register kb_data_avail each cycle; a capture occurs on the edge where kb_data_avail=1 and its registered value=0; exactly one capture per high period.
REQ-020 Capture writes {kb_data} to keyboard queue (kb_is_mouse=0) or mouse queue (kb_is_mouse=1) on that same edge.
REQ-021 Each queue: DEPTH-entry FIFO, wrapping read/write pointers, count 0..DEPTH; order preserved.
REQ-022 Capture into full queue with no same-edge pop: entry dropped, matching ovf flag set to 1; queue contents unchanged.
REQ-023 Capture into full queue with same-edge pop from that queue: entry accepted, no overflow.
REQ-024 Output slot: single register (evt_valid, evt_data, evt_is_mouse); loads from a queue when evt_valid=0 or (evt_valid & evt_ready); otherwise holds all three outputs stable.
REQ-025 Slot free and no queue non-empty: evt_valid goes 0 after acceptance.
REQ-026 Arbiter: round-robin with last_grant bit; both queues non-empty -> grant queue opposite last_grant; one non-empty -> grant it; last_grant updates on every grant.
REQ-027 Latency: capture at edge k into empty queues with free slot -> evt_valid=1 after edge k+1; a capture is never forwarded combinationally.
REQ-028 Sustained evt_ready=1 with both queues non-empty: one event per cycle, alternating keyboard/mouse.
REQ-029 LED scheduler: led_req latches led_val into pending register and sets led_pending; a newer led_req overwrites the pending value (last wins).
REQ-030 Gap counter: 16 bit; on issue loads LED_GAP-1, decrements to 0 and holds.
REQ-031 Issue when led_pending=1, gap counter=0, kb_data_avail=0: led_data_valid=1 for exactly one cycle, led_data=pending value, led_pending cleared.
REQ-032 led_req on the issue edge: new value becomes pending (led_pending stays 1), not lost; issued after gap expires.
REQ-033 led_data holds last issued value between pulses.
REQ-034 ovf_clr coincident with a new overflow: flag ends at 1 (set wins).

Reset
REQ-035 reset=1 asynchronously clears: both queues empty, pointers 0, evt_valid=0, evt_data=0, evt_is_mouse=0, led_data_valid=0, led_data=2'b00, led_pending=0, gap counter=0, kb_ovf=0, ms_ovf=0, last_grant=1 (keyboard granted first), registered kb_data_avail=0.
REQ-036 Reset mid-operation discards queued and pending data; kb_data_avail already high at reset release produces a capture on the first edge.

Verification
REQ-037 kb_data_avail high 5 cycles, kb_is_mouse=0, kb_data=16'h1234, evt_ready=1 -> one event 16'h1234, evt_is_mouse=0, evt_valid after edge k+1, exactly one cycle.
REQ-038 evt_ready=0, 5 keyboard captures 16'h0001..0005, DEPTH=4 -> slot holds 0001, queue 0002..0005, kb_ovf=0; 6th capture -> kb_ovf=1; ovf_clr -> kb_ovf=0; draining yields 0001..0005 in order.
REQ-039 Queue 2 keyboard (A1,A2) and 2 mouse (B1,B2) with evt_ready=0, then evt_ready=1 -> output order A1,B1,A2,B2 (or slot-first then alternating), evt_is_mouse 0,1,0,1.
REQ-040 led_req val=2'b11 at idle -> led_data_valid pulse next edge, led_data=11; led_req val=2'b01 then 2'b10 within LED_GAP -> single pulse with 10 exactly LED_GAP cycles after first pulse.
REQ-041 led_req while kb_data_avail=1 -> no pulse until kb_data_avail falls; then one pulse.
REQ-042 Assert reset with queues half full and led_pending=1 -> all outputs at REQ-035 values immediately, no led_data_valid pulse after release.
